// File: rtl/vme_cmd_responder.sv
// VME command responder: accepts a latched VME command, runs one register-bus
// cycle (read or write) with a strobe timeout, and returns a one-word result.
module vme_cmd_responder #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  SIG_BYTE = 8'hA8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic        vme_cmd_rd,
  output logic        vme_dat_wr,
  output logic [31:0] vme_dat_reg_out,
  output logic        bus_strobe,
  output logic        bus_write,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  output logic [15:0] cmd_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    STROBE  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // Wait count reached on the last strobe cycle that may still see an ack.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 32'd1);

  state_t      state;
  logic [31:0] cmd_r;
  logic [15:0] data_r;
  logic [15:0] wait_cnt;
  logic [15:0] cmd_count_inc;
  logic [7:0]  err_count_inc;
  logic        cmd_bad;

  // Result word: error forces the data field to zero.
  function automatic logic [31:0] pack_resp(input logic err, input logic tmo,
                                            input logic [1:0] rw, input logic [15:0] d);
    return {err, tmo, 4'b0000, rw, 8'h00, (err ? 16'h0000 : d)};
  endfunction

  assign cmd_count_inc = cmd_count + 16'd1;
  assign err_count_inc = (err_count == 8'hFF) ? err_count : (err_count + 8'd1);
  assign cmd_bad       = (cmd_r[23:16] != SIG_BYTE) || (cmd_r[25] == cmd_r[24]);

  // Command FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      vme_cmd_rd      <= 1'b1;
      vme_dat_wr      <= 1'b0;
      vme_dat_reg_out <= 32'h0000_0000;
      bus_strobe      <= 1'b0;
      bus_write       <= 1'b0;
      bus_addr        <= 16'h0000;
      bus_wdata       <= 16'h0000;
      cmd_count       <= 16'h0000;
      err_count       <= 8'h00;
      wait_cnt        <= 16'h0000;
      cmd_r           <= 32'h0000_0000;
      data_r          <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          vme_dat_wr <= 1'b0;
          if (start) begin
            cmd_r      <= vme_cmd_reg;
            data_r     <= vme_dat_reg_in[15:0];
            vme_cmd_rd <= 1'b0;
            state      <= DECODE;
          end else begin
            vme_cmd_rd <= 1'b1;
          end
        end
        DECODE: begin
          if (cmd_bad) begin
            vme_dat_reg_out <= pack_resp(1'b1, 1'b0, cmd_r[25:24], 16'h0000);
            vme_dat_wr      <= 1'b1;
            cmd_count       <= cmd_count_inc;
            err_count       <= err_count_inc;
            state           <= RESPOND;
          end else begin
            bus_strobe <= 1'b1;
            bus_addr   <= cmd_r[15:0];
            bus_write  <= cmd_r[24];
            bus_wdata  <= data_r;
            wait_cnt   <= 16'h0000;
            state      <= STROBE;
          end
        end
        STROBE: begin
          if (bus_ack) begin
            bus_strobe      <= 1'b0;
            vme_dat_reg_out <= pack_resp(1'b0, 1'b0, cmd_r[25:24],
                                         (cmd_r[25] ? bus_rdata : 16'h0000));
            vme_dat_wr      <= 1'b1;
            cmd_count       <= cmd_count_inc;
            state           <= RESPOND;
          end else if (wait_cnt == LAST_WAIT) begin
            bus_strobe      <= 1'b0;
            wait_cnt        <= wait_cnt + 16'd1;
            vme_dat_reg_out <= pack_resp(1'b1, 1'b1, cmd_r[25:24], 16'h0000);
            vme_dat_wr      <= 1'b1;
            cmd_count       <= cmd_count_inc;
            err_count       <= err_count_inc;
            state           <= RESPOND;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESPOND: begin
          vme_dat_wr <= 1'b0;
          vme_cmd_rd <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          vme_dat_wr <= 1'b0;
          vme_cmd_rd <= 1'b1;
          bus_strobe <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
